// File: rtl/debug_addr_scanner.sv
// Walks a debug read address through memory on divider ticks or push-button steps.
// It issues one read per advance and holds the returned word for the board display.
module debug_addr_scanner #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int ADDR_MIN = 0,
    parameter int ADDR_MAX = 255,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick_i,
    input  logic              run_i,
    input  logic              step_i,
    input  logic              dir_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              rd_en_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              busy_o
);
    localparam logic [ADDR_W-1:0] MIN_A    = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(ADDR_MAX);
    localparam logic [1:0]        LAT_LOAD = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_START,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t              state_reg;
    logic [2:0]          sync_meta_reg;   // {step, dir, run}
    logic [2:0]          sync_reg;
    logic                step_prev_reg;
    logic [1:0]          lat_cnt_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                rd_en_reg;
    logic [DATA_W-1:0]   data_reg;
    logic                data_valid_reg;
    logic                busy_reg;

    logic                run_s;
    logic                dir_s;
    logic                step_s;
    logic                step_pulse;
    logic                adv;
    logic [1:0]          lat_dec;
    logic [ADDR_W-1:0]   addr_next;

    assign run_s      = sync_reg[0];
    assign dir_s      = sync_reg[1];
    assign step_s     = sync_reg[2];
    assign step_pulse = step_s & ~step_prev_reg;
    assign adv        = run_s ? tick_i : step_pulse;
    assign lat_dec    = lat_cnt_reg - 2'd1;

    // Wrap inside [ADDR_MIN, ADDR_MAX] so an out-of-range address is never driven.
    always_comb begin
        addr_next = addr_reg;
        if (dir_s) begin
            addr_next = (addr_reg == MAX_A) ? MIN_A : addr_reg + ADDR_W'(1);
        end else begin
            addr_next = (addr_reg == MIN_A) ? MAX_A : addr_reg - ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= '0;
            sync_reg      <= '0;
            step_prev_reg <= 1'b0;
        end else begin
            sync_meta_reg <= {step_i, dir_i, run_i};
            sync_reg      <= sync_meta_reg;
            step_prev_reg <= step_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_START;
            lat_cnt_reg    <= '0;
            addr_reg       <= MIN_A;
            rd_en_reg      <= 1'b0;
            data_reg       <= '0;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b1;
        end else begin
            rd_en_reg      <= 1'b0;
            data_valid_reg <= 1'b0;
            case (state_reg)
                S_START: begin
                    state_reg <= S_ISSUE;
                    rd_en_reg <= 1'b1;
                    busy_reg  <= 1'b1;
                end
                S_IDLE: begin
                    // Advances arriving while a read is in flight are simply lost.
                    if (adv) begin
                        addr_reg  <= addr_next;
                        state_reg <= S_ISSUE;
                        rd_en_reg <= 1'b1;
                        busy_reg  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    lat_cnt_reg <= LAT_LOAD;
                    state_reg   <= (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
                end
                S_WAIT: begin
                    lat_cnt_reg <= lat_dec;
                    if (lat_dec == 2'd0) begin
                        state_reg <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    data_reg       <= rdata_i;
                    data_valid_reg <= 1'b1;
                    state_reg      <= S_IDLE;
                    busy_reg       <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_o       = addr_reg;
    assign rd_en_o      = rd_en_reg;
    assign data_o       = data_reg;
    assign data_valid_o = data_valid_reg;
    assign busy_o       = busy_reg;

endmodule
